// File: rtl/csa_ram_mc.sv
// csa_ram_mc: per-channel byte stuffing buffers streamed out as items, round-robin across channels.
// Define CSA_RAM_MC_DEBUG_BUF_EN to add a circular capture of accepted items (read at raddr 256+).
module csa_ram_mc #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int CH_NUM = 2,
  parameter int ITEM_NUM = 2,
  parameter int IN_ITEM_BYTES = 5,
  parameter int OUT_ITEM_BYTES = 6,
  parameter int DEBUG_BUF_SIZE = 300,
  localparam int NB = C_S_AXI_DATA_WIDTH / 8,
  localparam int CAP = ITEM_NUM * IN_ITEM_BYTES,
  localparam int CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1,
  localparam int CNT_W = $clog2(CAP + 1),
  localparam int OW = OUT_ITEM_BYTES * 8
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          rst,
  input  logic                          wen,
  input  logic [12:0]                   waddr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
  input  logic [NB-1:0]                 S_AXI_WSTRB,
  input  logic                          ren,
  input  logic [12:0]                   raddr,
  output logic [C_S_AXI_DATA_WIDTH-1:0] rdata,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OW-1:0]                 out_data,
  output logic [CH_W-1:0]               out_ch,
  output logic [CH_NUM-1:0]             ch_ready
);

  typedef enum logic [1:0] {IDLE = 2'd0, STUFF = 2'd1, STREAM = 2'd2} state_e;

  state_e                        state_q [CH_NUM], state_d [CH_NUM];
  logic [7:0]                    buf_q [CH_NUM][CAP], buf_d [CH_NUM][CAP];
  logic [CNT_W-1:0]              cnt_q [CH_NUM], cnt_d [CH_NUM];
  logic [7:0]                    items_q [CH_NUM], items_d [CH_NUM];
  logic [7:0]                    idx_q [CH_NUM], idx_d [CH_NUM];
  logic [15:0]                   loop_q [CH_NUM], loop_d [CH_NUM];
  logic [15:0]                   iter_q [CH_NUM], iter_d [CH_NUM];
  logic [CH_NUM-1:0]             done_q, done_d, err_q, err_d, ovf_q, ovf_d;
  logic [CH_W-1:0]               sel_q, sel_d, rr_q, rr_d, out_ch_q, out_ch_d;
  logic                          out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [OW-1:0]                 out_data_q, out_data_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic            accept, found;
  logic [CH_W-1:0] pick, wsel, ridx;
  logic [31:0]     word;
  int              pos, c, base;

`ifdef CSA_RAM_MC_DEBUG_BUF_EN
  localparam int DP_W = (DEBUG_BUF_SIZE > 1) ? $clog2(DEBUG_BUF_SIZE) : 1;
  logic [31:0]     dbg_mem_q [DEBUG_BUF_SIZE];
  logic [DP_W-1:0] dbg_ptr_q, dbg_ptr_d;
`endif

  assign accept = out_valid_q && out_ready;

  always_comb begin
    state_d = state_q;  buf_d = buf_q;    cnt_d = cnt_q;    items_d = items_q;
    idx_d = idx_q;      loop_d = loop_q;  iter_d = iter_q;  done_d = done_q;
    err_d = err_q;      ovf_d = ovf_q;    sel_d = sel_q;    rr_d = rr_q;
    out_valid_d = out_valid_q;  out_last_d = out_last_q;
    out_data_d = out_data_q;    out_ch_d = out_ch_q;
    rdata_d = '0;
    found = 1'b0;  pick = '0;  wsel = '0;  ridx = '0;  word = '0;
    pos = 0;  c = 0;  base = 0;
`ifdef CSA_RAM_MC_DEBUG_BUF_EN
    dbg_ptr_d = dbg_ptr_q;
`endif

    // Status read clears first so a same-cycle error/overflow event is not lost.
    if (ren) begin
      if (raddr == 13'd0) begin
        word[16 +: CH_NUM] = err_q;
        word[0 +: CH_NUM]  = ovf_q;
        rdata_d = C_S_AXI_DATA_WIDTH'(word);
        err_d = '0;
        ovf_d = '0;
      end else if (raddr <= 13'(CH_NUM)) begin
        ridx = CH_W'(raddr - 13'd1);
        word = {loop_q[ridx] - iter_q[ridx], 6'd0, items_q[ridx], state_q[ridx]};
        rdata_d = C_S_AXI_DATA_WIDTH'(word);
      end
`ifdef CSA_RAM_MC_DEBUG_BUF_EN
      else if (raddr >= 13'd256 && raddr < 13'(256 + DEBUG_BUF_SIZE)) begin
        rdata_d = C_S_AXI_DATA_WIDTH'(dbg_mem_q[raddr - 13'd256]);
      end
`endif
    end

    if (accept) begin
      out_valid_d = 1'b0;
      if (out_last_q) state_d[out_ch_q] = IDLE;
`ifdef CSA_RAM_MC_DEBUG_BUF_EN
      dbg_ptr_d = (dbg_ptr_q == DP_W'(DEBUG_BUF_SIZE - 1)) ? '0 : dbg_ptr_q + 1'b1;
`endif
    end

    // Items are issued into the output register; a channel retires when its last item is accepted.
    if (!out_valid_q || out_ready) begin
      for (int k = 1; k <= CH_NUM; k++) begin
        c = int'(rr_q) + k;
        if (c >= CH_NUM) c = c - CH_NUM;
        if (!found && state_q[CH_W'(c)] == STREAM && !done_q[CH_W'(c)]) begin
          found = 1'b1;
          pick = CH_W'(c);
        end
      end
      if (found) begin
        out_valid_d = 1'b1;
        out_ch_d = pick;
        rr_d = pick;
        base = int'(idx_q[pick]) * IN_ITEM_BYTES;
        out_data_d = OW'((OW + 16)'(iter_q[pick]) << (IN_ITEM_BYTES * 8));
        for (int b = 0; b < IN_ITEM_BYTES; b++) begin
          if (base + b < CAP) out_data_d[b*8 +: 8] = buf_q[pick][base + b];
        end
        out_last_d = 1'b0;
        if (idx_q[pick] == items_q[pick] - 8'd1) begin
          idx_d[pick] = '0;
          iter_d[pick] = iter_q[pick] + 16'd1;
          if (iter_q[pick] == loop_q[pick] - 16'd1) begin
            done_d[pick] = 1'b1;
            out_last_d = 1'b1;
          end
        end else begin
          idx_d[pick] = idx_q[pick] + 8'd1;
        end
      end
    end

    if (wen) begin
      case (waddr)
        13'd0: begin
          if (int'(S_AXI_WDATA[3:0]) < CH_NUM) begin
            wsel = CH_W'(S_AXI_WDATA[3:0]);
            if (state_q[wsel] != IDLE) begin
              err_d[wsel] = 1'b1;
            end else begin
              // A new request abandons any channel still being stuffed.
              for (int n = 0; n < CH_NUM; n++) begin
                if (state_q[n] == STUFF) state_d[n] = IDLE;
              end
              state_d[wsel] = STUFF;
              cnt_d[wsel] = '0;
              sel_d = wsel;
            end
          end
        end
        13'd1: begin
          if (state_q[sel_q] == STUFF) begin
            pos = int'(cnt_q[sel_q]);
            for (int l = 0; l < NB; l++) begin
              if (S_AXI_WSTRB[l]) begin
                if (pos < CAP) begin
                  buf_d[sel_q][pos] = S_AXI_WDATA[l*8 +: 8];
                  pos = pos + 1;
                end else begin
                  ovf_d[sel_q] = 1'b1;
                end
              end
            end
            cnt_d[sel_q] = CNT_W'(pos);
          end
        end
        13'd2: begin
          if (state_q[sel_q] == STUFF) begin
            items_d[sel_q] = 8'(cnt_q[sel_q] / CNT_W'(IN_ITEM_BYTES));
            loop_d[sel_q] = S_AXI_WDATA[15:0];
            iter_d[sel_q] = '0;
            idx_d[sel_q] = '0;
            done_d[sel_q] = 1'b0;
            if (S_AXI_WDATA[15:0] == 16'd0 || cnt_q[sel_q] < CNT_W'(IN_ITEM_BYTES))
              state_d[sel_q] = IDLE;
            else
              state_d[sel_q] = STREAM;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < CH_NUM; n++) begin
        state_q[n] <= IDLE;
        cnt_q[n]   <= '0;
        items_q[n] <= '0;
        idx_q[n]   <= '0;
        loop_q[n]  <= '0;
        iter_q[n]  <= '0;
        for (int j = 0; j < CAP; j++) buf_q[n][j] <= '0;
      end
      done_q <= '0;  err_q <= '0;  ovf_q <= '0;
      sel_q <= '0;   rr_q <= '0;   out_ch_q <= '0;
      out_valid_q <= 1'b0;  out_last_q <= 1'b0;
      out_data_q <= '0;     rdata_q <= '0;
    end else begin
      state_q <= state_d;  buf_q <= buf_d;    cnt_q <= cnt_d;    items_q <= items_d;
      idx_q <= idx_d;      loop_q <= loop_d;  iter_q <= iter_d;  done_q <= done_d;
      err_q <= err_d;      ovf_q <= ovf_d;    sel_q <= sel_d;    rr_q <= rr_d;
      out_ch_q <= out_ch_d;  out_valid_q <= out_valid_d;  out_last_q <= out_last_d;
      out_data_q <= out_data_d;  rdata_q <= rdata_d;
    end
  end

`ifdef CSA_RAM_MC_DEBUG_BUF_EN
  always_ff @(posedge S_AXI_ACLK or posedge rst) begin
    if (rst) dbg_ptr_q <= '0;
    else     dbg_ptr_q <= dbg_ptr_d;
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (accept) dbg_mem_q[dbg_ptr_q] <= out_data_q[31:0];
  end
`endif

  always_comb begin
    ch_ready = '0;
    for (int n = 0; n < CH_NUM; n++) ch_ready[n] = (state_q[n] == IDLE);
  end

  assign rdata     = rdata_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_csa_ram_mc.sv
// tb_csa_ram_mc: directed bench for csa_ram_mc at default parameters.
`timescale 1ns/1ps
module tb_csa_ram_mc;

  logic        S_AXI_ACLK = 1'b0;
  logic        rst, wen, ren, out_ready, out_valid;
  logic [12:0] waddr, raddr;
  logic [31:0] S_AXI_WDATA, rdata;
  logic [3:0]  S_AXI_WSTRB;
  logic [47:0] out_data;
  logic [0:0]  out_ch;
  logic [1:0]  ch_ready;

  int n_vec = 0;
  int n_miss = 0;
  logic [47:0] q_data[$];
  int          q_ch[$];
  int          q_cyc[$];

  localparam logic [39:0] A0 = 40'h0504030201, A1 = 40'h0A09080706;
  localparam logic [39:0] B0 = 40'h1514131211, B1 = 40'h1A19181716;

  csa_ram_mc dut (
    .S_AXI_ACLK(S_AXI_ACLK), .rst(rst), .wen(wen), .waddr(waddr),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .ren(ren), .raddr(raddr),
    .rdata(rdata), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .ch_ready(ch_ready)
  );

  always #5 S_AXI_ACLK = ~S_AXI_ACLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [12:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge S_AXI_ACLK);
    wen = 1'b1; waddr = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
    @(negedge S_AXI_ACLK);
    wen = 1'b0;
  endtask

  task automatic rd(input logic [12:0] a, output logic [31:0] d);
    @(negedge S_AXI_ACLK);
    ren = 1'b1; raddr = a;
    @(negedge S_AXI_ACLK);
    ren = 1'b0;
    d = rdata;
  endtask

  task automatic stuff10(input logic [31:0] ch, input logic [31:0] w0, input logic [31:0] w1,
                         input logic [31:0] w2, input logic [3:0] s2, input logic [31:0] loops);
    wr(13'd0, ch, 4'h0);
    wr(13'd1, w0, 4'hF);
    wr(13'd1, w1, 4'hF);
    wr(13'd1, w2, s2);
    wr(13'd2, loops, 4'h0);
  endtask

  // Accepts n items; at item index stall_at holds out_ready low for 5 cycles.
  task automatic collect(input int n, input int stall_at);
    int got = 0, cyc = 0, stall = 0;
    logic [47:0] held = '0;
    q_data.delete(); q_ch.delete(); q_cyc.delete();
    while (got < n) begin
      @(negedge S_AXI_ACLK);
      cyc++;
      if (cyc > 3 * n + 20) begin
        chk("collect_timeout", 64'(got), 64'(n));
        out_ready = 1'b0;
        return;
      end
      if (got == stall_at && stall < 5 && out_valid) begin
        if (stall == 0) held = out_data;
        else chk($sformatf("stall_hold%0d", stall), out_data, held);
        out_ready = 1'b0;
        stall++;
      end else begin
        out_ready = 1'b1;
        if (out_valid) begin
          q_data.push_back(out_data);
          q_ch.push_back(int'(out_ch));
          q_cyc.push_back(cyc);
          got++;
        end
      end
    end
  endtask

  function automatic logic [47:0] item(input logic [39:0] b0, input logic [39:0] b1, input int k);
    logic [7:0] it;
    it = 8'(k / 2);
    return (k % 2 == 0) ? {it, b0} : {it, b1};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    rst = 1'b1; wen = 1'b0; ren = 1'b0; out_ready = 1'b0;
    waddr = '0; raddr = '0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0;
    repeat (3) @(negedge S_AXI_ACLK);
    chk("rst_ch_ready", 64'(ch_ready), 64'h3);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_data", 64'(out_data), 64'h0);
    chk("rst_out_ch", 64'(out_ch), 64'h0);
    chk("rst_rdata", 64'(rdata), 64'h0);
    rst = 1'b0;

    // 12 bytes into a 10-byte buffer, loop 4, with a 5-cycle stall mid-stream
    wr(13'd0, 32'd0, 4'h0);
    chk("stuff_ch_ready", 64'(ch_ready), 64'h2);
    wr(13'd1, 32'h04030201, 4'hF);
    wr(13'd1, 32'h08070605, 4'hF);
    wr(13'd1, 32'h0C0B0A09, 4'hF);
    rd(13'd0, d); chk("ovf_status", 64'(d), 64'h1);
    rd(13'd0, d); chk("status_cleared", 64'(d), 64'h0);
    wr(13'd2, 32'd4, 4'h0);
    chk("fin_lat_1", 64'(out_valid), 64'h0);
    @(negedge S_AXI_ACLK);
    chk("fin_lat_2", 64'(out_valid), 64'h1);
    chk("first_item", 64'(out_data), 64'h000504030201);
    chk("first_ch", 64'(out_ch), 64'h0);
    rd(13'd1, d); chk("ch0_regs", 64'(d), 64'h0004000A);
    collect(8, 3);
    chk("t1_count", 64'(q_data.size()), 64'd8);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t1_item%0d", k), 64'(q_data[k]), 64'(item(A0, A1, k)));
      chk($sformatf("t1_ch%0d", k), 64'(q_ch[k]), 64'd0);
    end
    chk("t1_rate_pre", 64'(q_cyc[2] - q_cyc[0]), 64'd2);
    chk("t1_rate_post", 64'(q_cyc[7] - q_cyc[3]), 64'd4);
    @(negedge S_AXI_ACLK);
    out_ready = 1'b0;
    chk("t1_idle", 64'(ch_ready), 64'h3);
    chk("t1_valid_low", 64'(out_valid), 64'h0);

    // two channels, strobed tails, round-robin; plus busy and out-of-range requests
    stuff10(32'd0, 32'h04030201, 32'h08070605, 32'h00000A09, 4'b0011, 32'd1);
    stuff10(32'd1, 32'h14131211, 32'h18171615, 32'h1A001900, 4'b1010, 32'd1);
    wr(13'd0, 32'd0, 4'h0);
    wr(13'd0, 32'd5, 4'h0);
    rd(13'd0, d); chk("err_status", 64'(d), 64'h00010000);
    rd(13'd1, d); chk("ch0_regs_rr", 64'(d), 64'h0001000A);
    rd(13'd2, d); chk("ch1_regs_rr", 64'(d), 64'h0001000A);
    collect(4, -1);
    chk("rr_ch0", 64'(q_ch[0]), 64'd0);
    chk("rr_ch1", 64'(q_ch[1]), 64'd1);
    chk("rr_ch2", 64'(q_ch[2]), 64'd0);
    chk("rr_ch3", 64'(q_ch[3]), 64'd1);
    chk("rr_d0", 64'(q_data[0]), {24'h0, A0});
    chk("rr_d1", 64'(q_data[1]), {24'h0, B0});
    chk("rr_d2", 64'(q_data[2]), {24'h0, A1});
    chk("rr_d3", 64'(q_data[3]), {24'h0, B1});
    chk("rr_rate", 64'(q_cyc[3] - q_cyc[0]), 64'd3);
    @(negedge S_AXI_ACLK);
    out_ready = 1'b0;
    chk("rr_idle", 64'(ch_ready), 64'h3);

    // data / fin with no channel in STUFF
    wr(13'd1, 32'hFFFFFFFF, 4'hF);
    wr(13'd2, 32'd3, 4'h0);
    repeat (2) @(negedge S_AXI_ACLK);
    chk("orphan_valid", 64'(out_valid), 64'h0);
    chk("orphan_ready", 64'(ch_ready), 64'h3);
    rd(13'd0, d); chk("orphan_status", 64'(d), 64'h0);

    // loop 0 and zero complete items both return straight to IDLE
    stuff10(32'd0, 32'h04030201, 32'h08070605, 32'h00000A09, 4'b0011, 32'd0);
    chk("loop0_ready", 64'(ch_ready), 64'h3);
    for (int k = 0; k < 3; k++) begin
      @(negedge S_AXI_ACLK);
      chk($sformatf("loop0_valid%0d", k), 64'(out_valid), 64'h0);
    end
    wr(13'd0, 32'd0, 4'h0);
    wr(13'd1, 32'h04030201, 4'hF);
    wr(13'd2, 32'd2, 4'h0);
    @(negedge S_AXI_ACLK);
    chk("items0_ready", 64'(ch_ready), 64'h3);
    chk("items0_valid", 64'(out_valid), 64'h0);

    // reset while channel 1 streams
    stuff10(32'd1, 32'h14131211, 32'h18171615, 32'h1A001900, 4'b1010, 32'd5);
    @(negedge S_AXI_ACLK);
    out_ready = 1'b1;
    repeat (2) @(negedge S_AXI_ACLK);
    chk("mid_valid", 64'(out_valid), 64'h1);
    chk("mid_ch", 64'(out_ch), 64'h1);
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", 64'(out_valid), 64'h0);
    chk("rst_mid_data", 64'(out_data), 64'h0);
    chk("rst_mid_ready", 64'(ch_ready), 64'h3);
    @(negedge S_AXI_ACLK);
    rst = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge S_AXI_ACLK);
    chk("post_rst_valid", 64'(out_valid), 64'h0);
    rd(13'd2, d); chk("post_rst_ch1", 64'(d), 64'h0);

    // long run: 302 accepted items, debug buffer wraps
    stuff10(32'd0, 32'h04030201, 32'h08070605, 32'h00000A09, 4'b0011, 32'd151);
    collect(302, -1);
    chk("long_count", 64'(q_data.size()), 64'd302);
    chk("long_first", 64'(q_data[0]), 64'h000504030201);
    chk("long_300", 64'(q_data[300]), 64'h960504030201);
    chk("long_301", 64'(q_data[301]), 64'h960A09080706);
    chk("long_rate", 64'(q_cyc[301] - q_cyc[0]), 64'd301);
    @(negedge S_AXI_ACLK);
    out_ready = 1'b0;
    chk("long_idle", 64'(ch_ready), 64'h3);
    rd(13'd256, d);
`ifdef CSA_RAM_MC_DEBUG_BUF_EN
    chk("dbg_256", 64'(d), 64'h04030201);
    rd(13'd257, d); chk("dbg_257", 64'(d), 64'h09080706);
`else
    chk("dbg_256", 64'(d), 64'h0);
`endif
    rd(13'd10, d); chk("unmapped", 64'(d), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/csa_ram_mc.md
CSA_RAM_MC -- requirements
Module: csa_ram_mc

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32: write/read data width in bits (multiple of 8).
REQ-002 SHALL have parameter CH_NUM, default 2: number of independent stuffing channels (1..16).
REQ-003 SHALL have parameter ITEM_NUM, default 2: maximum items per channel buffer.
REQ-004 SHALL have parameter IN_ITEM_BYTES, default 5, and OUT_ITEM_BYTES, default 6: stored and emitted item sizes, with OUT_ITEM_BYTES >= IN_ITEM_BYTES.
REQ-005 SHALL have parameter DEBUG_BUF_SIZE, default 300: debug capture depth in words.
REQ-006 SHALL use one clock; reset is asynchronous and active-high.
REQ-007 SHALL have the following ports, clock and reset first:
  S_AXI_ACLK  in  1  sole clock, rising edge
  rst  in  1  asynchronous active-high reset
  wen  in  1  write strobe, one command per cycle
  waddr  in  13  command: 0 REQ_STUFF, 1 STUFFING_DATA, 2 FIN_STUFF, other values ignored
  S_AXI_WDATA  in  C_S_AXI_DATA_WIDTH  command payload
  S_AXI_WSTRB  in  C_S_AXI_DATA_WIDTH/8  byte enables for STUFFING_DATA
  ren  in  1  read strobe
  raddr  in  13  read address
  rdata  out  C_S_AXI_DATA_WIDTH  read data, 1-cycle latency
  out_valid  out  1  output item valid
  out_ready  in  1  output item accepted when high with out_valid
  out_data  out  OUT_ITEM_BYTES*8  item, byte 0 in [7:0]
  out_ch  out  clog2(CH_NUM) (min 1)  channel of out_data
  ch_ready  out  CH_NUM  bit n high when channel n is IDLE

Function
REQ-008 Each channel SHALL run FSM IDLE -> STUFF (REQ_STUFF) -> STREAM (FIN_STUFF) -> IDLE (last item accepted).
REQ-009 REQ_STUFF SHALL select channel WDATA[3:0]; out-of-range channel or non-IDLE channel -> ignored, err bit of that channel set.
REQ-010 STUFFING_DATA SHALL append enabled bytes (ascending lane order) to the selected STUFF channel; bytes beyond ITEM_NUM*IN_ITEM_BYTES dropped, overflow bit set.
REQ-011 FIN_STUFF SHALL latch loop count = WDATA[15:0] and items = floor(bytes/IN_ITEM_BYTES); loop 0 or items 0 -> channel returns to IDLE with no output.
REQ-012 STREAM SHALL emit items 0..items-1, repeated loop times; out_data = stored item in low bytes, iteration index (zero-extended/truncated) in upper OUT_ITEM_BYTES-IN_ITEM_BYTES bytes.
REQ-013 out_valid, out_data and out_ch SHALL stay stable until accepted; first item valid 2 cycles after FIN_STUFF write.
REQ-014 Multiple STREAM channels SHALL be served round-robin per accepted item, starting after the last-served channel.
REQ-015 Back-to-back accepted items on one channel SHALL sustain one item per cycle.
REQ-016 raddr 0 SHALL read status {err[CH_NUM], overflow[CH_NUM]} bits 31:16 / 15:0, packed from bit 0; reading clears both.
REQ-017 raddr 1+n SHALL read channel n: state [1:0], items [9:2], remaining loops [31:16].
REQ-018 STUFFING_DATA or FIN_STUFF with no channel in STUFF SHALL be ignored.

Reset
REQ-019 rst SHALL force all channels IDLE, ch_ready all ones, out_valid 0, out_data 0, out_ch 0, rdata 0, err/overflow 0, round-robin pointer 0, debug write pointer 0.
REQ-020 rst asserted mid-stream SHALL drop the item in flight with no further outputs.

Configuration
REQ-021 Macro CSA_RAM_MC_DEBUG_BUF_EN defined: each accepted item's low 32 bits written to circular buffer; raddr 256..256+DEBUG_BUF_SIZE-1 reads it, wrap after DEBUG_BUF_SIZE.
REQ-022 Macro undefined: no buffer instantiated; raddr 256 and above read 0.

Verification
REQ-023 REQ_STUFF ch0, 3 words 0x04030201,0x08070605,0x0C0B0A09, FIN loop 4 -> 8 items, first 0x000504030201, second 0x000A09080706, iteration 1 items upper byte 0x01.
REQ-024 Channels 0 and 1 stuffed with 2 items each, loop 1, out_ready held 1 -> out_ch sequence 0,1,0,1, one item per cycle.
REQ-025 out_ready low 5 cycles mid-stream -> out_data unchanged, no item lost or duplicated.
REQ-026 Stuff 12 bytes with ITEM_NUM 2 -> overflow bit 0 in status read, 2 items emitted; second status read returns 0.
REQ-027 FIN_STUFF loop 0 -> no out_valid, ch_ready[0] returns 1; rst during stream -> out_valid 0 next cycle.
REQ-028 With macro defined, after 302 accepted items -> raddr 256 returns item 300 low word; without macro -> 0.
